// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state encoding and bus width defaults for the memory responder
package mem_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    function automatic logic is_busy_state(input mem_state_t s);
        return (s == WR) || (s == RD);
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - saturating cycle counter with limit compare for external-bus timeouts
module mem_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over counting; the counter parks at the limit instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - core data-memory responder driving a wait-stated external bus; optional MEM_TIMEOUT_EN watchdog
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_read,
    input  logic              ram_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_busy,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    output logic              ext_we,
    output logic              ext_req,
    input  logic              ext_ack,
    input  logic [DATA_W-1:0] ext_rdata,
    output logic              mem_err
);

    mem_state_t        state_q,     state_d;
    logic [ADDR_W-1:0] ext_addr_q,  ext_addr_d;
    logic [DATA_W-1:0] ext_wdata_q, ext_wdata_d;
    logic              ext_we_q,    ext_we_d;
    logic              ext_req_q,   ext_req_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              busy_q,      busy_d;
    logic              ready_q,     ready_d;
    logic              err_q,       err_d;
    logic              tmo_expired;

`ifdef MEM_TIMEOUT_EN
    // Counter is held clear outside WR/RD so it starts from zero on every entry.
    mem_watchdog #(
        .LIMIT (TMO_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!is_busy_state(state_q)),
        .run     (ext_req_q && !ext_ack),
        .expired (tmo_expired)
    );
`else
    logic unused_tmo;
    assign unused_tmo  = (TMO_CYC == 0);
    assign tmo_expired = 1'b0;
`endif

    // Next-state and registered-output computation; an ack always beats a timeout.
    always_comb begin
        state_d     = state_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        ext_we_d    = ext_we_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (ram_write) begin
                    ext_addr_d  = addr;
                    ext_wdata_d = wdata;
                    ext_we_d    = 1'b1;
                    state_d     = WR;
                end else if (ram_read) begin
                    ext_addr_d = addr;
                    ext_we_d   = 1'b0;
                    state_d    = RD;
                end
            end
            WR: begin
                if (ext_ack) begin
                    state_d = IDLE;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            RD: begin
                if (ext_ack) begin
                    rdata_d = ext_rdata;
                    state_d = DONE;
                end else if (tmo_expired) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ext_req_d = is_busy_state(state_d);
        busy_d    = is_busy_state(state_d);
        ready_d   = (state_d == DONE);
    end

    // State and output registers; reset drops any in-flight request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            ext_we_q    <= 1'b0;
            ext_req_q   <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            ext_we_q    <= ext_we_d;
            ext_req_q   <= ext_req_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    assign rdata     = rdata_q;
    assign mem_busy  = busy_q;
    assign mem_ready = ready_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;
    assign ext_we    = ext_we_q;
    assign ext_req   = ext_req_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (covers both MEM_TIMEOUT_EN builds)
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_read, ram_write;
    logic [15:0] addr, wdata, rdata;
    logic        mem_busy, mem_ready;
    logic [15:0] ext_addr, ext_wdata;
    logic        ext_we, ext_req, ext_ack;
    logic [15:0] ext_rdata;
    logic        mem_err;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];
    bit          err_expected = 1'b0;
    bit          prev_ready = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TMO_CYC (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .mem_busy  (mem_busy),
        .mem_ready (mem_ready),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_we    (ext_we),
        .ext_req   (ext_req),
        .ext_ack   (ext_ack),
        .ext_rdata (ext_rdata),
        .mem_err   (mem_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every mem_ready pops one expected read value.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ready = 1'b0;
        end else begin
            if (mem_ready) begin
                if (exp_q.size() == 0) flag("unexpected_ready", 32'(rdata));
                else chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
                if (prev_ready) flag("double_ready", 32'(rdata));
            end
            if (mem_err && !err_expected) flag("unexpected_err", 32'(mem_err));
            prev_ready = mem_ready;
        end
    end

    task automatic do_read(input logic [15:0] a, input logic [15:0] d, input int waits);
        ram_read = 1'b1;
        addr     = a;
        tick();
        ram_read = 1'b0;
        chk("rd_busy", 32'(mem_busy), 1);
        chk("rd_req", 32'(ext_req), 1);
        chk("rd_we", 32'(ext_we), 0);
        chk("rd_addr", 32'(ext_addr), 32'(a));
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("rd_busy_wait", 32'(mem_busy), 1);
            chk("rd_addr_hold", 32'(ext_addr), 32'(a));
        end
        ext_ack   = 1'b1;
        ext_rdata = d;
        exp_q.push_back(d);
        tick();
        ext_ack   = 1'b0;
        ext_rdata = 16'h0;
        chk("rd_busy_after", 32'(mem_busy), 0);
        chk("rd_req_after", 32'(ext_req), 0);
        tick();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int waits,
                            input bit with_read);
        ram_write = 1'b1;
        ram_read  = with_read;
        addr      = a;
        wdata     = d;
        tick();
        ram_write = 1'b0;
        ram_read  = 1'b0;
        chk("wr_busy", 32'(mem_busy), 1);
        chk("wr_we", 32'(ext_we), 1);
        chk("wr_addr", 32'(ext_addr), 32'(a));
        chk("wr_wdata", 32'(ext_wdata), 32'(d));
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("wr_busy_wait", 32'(mem_busy), 1);
            chk("wr_we_hold", 32'(ext_we), 1);
        end
        ext_ack = 1'b1;
        tick();
        ext_ack = 1'b0;
        chk("wr_busy_after", 32'(mem_busy), 0);
        chk("wr_req_after", 32'(ext_req), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int err_cnt;
        int busy_low;
        rst_n     = 1'b0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        addr      = 16'h0;
        wdata     = 16'h0;
        ext_ack   = 1'b0;
        ext_rdata = 16'h0;
        #12;
        chk("rst_busy", 32'(mem_busy), 0);
        chk("rst_ready", 32'(mem_ready), 0);
        chk("rst_req", 32'(ext_req), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_ext_addr", 32'(ext_addr), 0);
        chk("rst_err", 32'(mem_err), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Zero-wait read, then five wait states.
        do_read(16'h0040, 16'hBEEF, 0);
        do_read(16'h0040, 16'h1357, 5);

        // Posted write, then simultaneous read+write (write wins).
        do_write(16'h1234, 16'h00FF, 3, 1'b0);
        do_write(16'h2222, 16'hA5A5, 1, 1'b1);

        // Stray ack while idle.
        ext_ack = 1'b1;
        tick();
        ext_ack = 1'b0;
        chk("idle_ack_busy", 32'(mem_busy), 0);
        chk("idle_ack_req", 32'(ext_req), 0);

        // Asynchronous reset mid-read.
        ram_read = 1'b1;
        addr     = 16'h0200;
        tick();
        ram_read = 1'b0;
        chk("pre_rst_req", 32'(ext_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(ext_req), 0);
        chk("mid_rst_busy", 32'(mem_busy), 0);
        chk("mid_rst_rdata", 32'(rdata), 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_read(16'h0300, 16'h5A5A, 2);

        // Read with no ack.
`ifdef MEM_TIMEOUT_EN
        err_expected = 1'b1;
        exp_q.push_back(16'hFFFF);
        ram_read = 1'b1;
        addr     = 16'h0400;
        tick();
        ram_read = 1'b0;
        err_cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_err) err_cnt++;
        end
        chk("tmo_err_pulses", 32'(err_cnt), 1);
        chk("tmo_busy_after", 32'(mem_busy), 0);
        chk("tmo_rdata", 32'(rdata), 32'hFFFF);
        err_expected = 1'b0;
`else
        ram_read = 1'b1;
        addr     = 16'h0400;
        tick();
        ram_read = 1'b0;
        err_cnt  = 0;
        busy_low = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (mem_err) err_cnt++;
            if (!mem_busy) busy_low++;
        end
        chk("notmo_err", 32'(err_cnt), 0);
        chk("notmo_busy_low", 32'(busy_low), 0);
        chk("notmo_req", 32'(ext_req), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
